draw_sprite_blit: RTL and testbench

- Parametrised successor to the fixed 5x5 single-direction pacman drawers.
- Draws one frame of a multi-frame sprite ROM (up/down/left/right, ghosts) at (startx, starty) into the VGA framebuffer.
- Uses a start/done handshake and a pipelined external ROM read. Supports an erase mode that paints the background colour over the sprite footprint.
- Sits between the game-control FSM and the VGA adapter write port.

---
 rtl/draw_sprite_pkg.sv | 23 ++
 rtl/sprite_addr_gen.sv | 68 ++++++
 rtl/draw_sprite_blit.sv | 152 +++++++++++++++
 tb/tb_draw_sprite_blit.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/draw_sprite_pkg.sv
// rtl/draw_sprite_pkg.sv - state encoding, frame indices and colour constants for the sprite blitter
package draw_sprite_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      FLUSH = 2'd2,
      DONE  = 2'd3
   } blit_state_t;

   localparam int FRAME_UP    = 0;
   localparam int FRAME_DOWN  = 1;
   localparam int FRAME_LEFT  = 2;
   localparam int FRAME_RIGHT = 3;

   localparam int BLACK  = 0;
   localparam int YELLOW = 6;

   function automatic int clamp_frame(input int frame, input int num_frames);
      return (frame >= num_frames) ? num_frames - 1 : frame;
   endfunction

endpackage

// File: rtl/sprite_addr_gen.sv
// rtl/sprite_addr_gen.sv - raster ax/ay counter and registered ROM address for one sprite frame
module sprite_addr_gen #(
   parameter int SPRITE_W = 5,
   parameter int SPRITE_H = 5,
   parameter int ADDR_W   = 7,
   parameter int FRAME_W  = 2,
   parameter int AX_W     = 3,
   parameter int AY_W     = 3
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              load,
   input  logic              advance,
   input  logic [FRAME_W-1:0] frame,
   output logic [AX_W-1:0]   ax,
   output logic [AY_W-1:0]   ay,
   output logic [ADDR_W-1:0] rom_addr,
   output logic              last
);

   localparam logic [ADDR_W-1:0] FRAME_SIZE = ADDR_W'(SPRITE_W * SPRITE_H);
   localparam logic [ADDR_W-1:0] ROW_SIZE   = ADDR_W'(SPRITE_W);
   localparam logic [AX_W-1:0]   AX_LAST    = AX_W'(SPRITE_W - 1);
   localparam logic [AY_W-1:0]   AY_LAST    = AY_W'(SPRITE_H - 1);

   logic [FRAME_W-1:0] frame_q;
   logic [FRAME_W-1:0] frame_nx;
   logic [AX_W-1:0]    ax_nx;
   logic [AY_W-1:0]    ay_nx;
   logic [ADDR_W-1:0]  addr_nx;

   assign last = (ax == AX_LAST) && (ay == AY_LAST);

   // The address is computed from the next counter values so rom_addr is a register.
   always_comb begin
      frame_nx = frame_q;
      ax_nx    = ax;
      ay_nx    = ay;
      if (load) begin
         frame_nx = frame;
         ax_nx    = '0;
         ay_nx    = '0;
      end else if (advance) begin
         if (ax == AX_LAST) begin
            ax_nx = '0;
            ay_nx = ay + AY_W'(1);
         end else begin
            ax_nx = ax + AX_W'(1);
         end
      end
      addr_nx = ADDR_W'(frame_nx) * FRAME_SIZE + ADDR_W'(ay_nx) * ROW_SIZE + ADDR_W'(ax_nx);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         frame_q  <= '0;
         ax       <= '0;
         ay       <= '0;
         rom_addr <= '0;
      end else begin
         frame_q  <= frame_nx;
         ax       <= ax_nx;
         ay       <= ay_nx;
         rom_addr <= addr_nx;
      end
   end

endmodule

// File: rtl/draw_sprite_blit.sv
// rtl/draw_sprite_blit.sv - draws or erases one sprite frame into the VGA write port; DRAW_SPRITE_TRANSPARENT_EN adds colour-key suppression
module draw_sprite_blit
   import draw_sprite_pkg::*;
#(
   parameter int SPRITE_W   = 5,
   parameter int SPRITE_H   = 5,
   parameter int NUM_FRAMES = 4,
   parameter int X_W        = 8,
   parameter int Y_W        = 7,
   parameter int COLOUR_W   = 3,
   parameter int ADDR_W     = 7,
   parameter int FRAME_W    = 2
`ifdef DRAW_SPRITE_TRANSPARENT_EN
   ,
   parameter logic [COLOUR_W-1:0] TRANSPARENT_KEY = '0
`endif
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                start,
   input  logic [FRAME_W-1:0]  frame_sel,
   input  logic [X_W-1:0]      startx,
   input  logic [Y_W-1:0]      starty,
   input  logic                erase,
   input  logic [COLOUR_W-1:0] bg_colour,
   output logic [ADDR_W-1:0]   rom_addr,
   input  logic [COLOUR_W-1:0] rom_q,
   output logic [X_W-1:0]      x,
   output logic [Y_W-1:0]      y,
   output logic [COLOUR_W-1:0] colour,
   output logic                plot,
   output logic                busy,
   output logic                done
);

   localparam int AX_W = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
   localparam int AY_W = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;

   blit_state_t         state;
   blit_state_t         state_nx;
   logic                load;
   logic                issue_valid;
   logic                advance;
   logic                last;
   logic [AX_W-1:0]     ax;
   logic [AY_W-1:0]     ay;
   logic [AX_W-1:0]     ax_d;
   logic [AY_W-1:0]     ay_d;
   logic                v_d;
   logic                last_d;
   logic                pix_show;
   logic [FRAME_W-1:0]  frame_clamped;
   logic [X_W-1:0]      startx_q;
   logic [Y_W-1:0]      starty_q;
   logic                erase_q;
   logic [COLOUR_W-1:0] bg_q;

   assign frame_clamped = FRAME_W'(clamp_frame(int'(frame_sel), NUM_FRAMES));

   sprite_addr_gen #(
      .SPRITE_W (SPRITE_W),
      .SPRITE_H (SPRITE_H),
      .ADDR_W   (ADDR_W),
      .FRAME_W  (FRAME_W),
      .AX_W     (AX_W),
      .AY_W     (AY_W)
   ) u_addr_gen (
      .clock    (clock),
      .reset    (reset),
      .load     (load),
      .advance  (advance),
      .frame    (frame_clamped),
      .ax       (ax),
      .ay       (ay),
      .rom_addr (rom_addr),
      .last     (last)
   );

   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   // ISSUE lingers one cycle past the last address so that FLUSH lines up with the last plot.
   always_comb begin
      state_nx    = state;
      load        = 1'b0;
      issue_valid = 1'b0;
      advance     = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               load     = 1'b1;
               state_nx = ISSUE;
            end
         end
         ISSUE: begin
            issue_valid = !last_d;
            advance     = !last_d && !last;
            if (last_d) state_nx = FLUSH;
         end
         FLUSH:   state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

`ifdef DRAW_SPRITE_TRANSPARENT_EN
   assign pix_show = v_d && (erase_q || (rom_q != TRANSPARENT_KEY));
`else
   assign pix_show = v_d;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         busy     <= 1'b0;
         done     <= 1'b0;
         plot     <= 1'b0;
         x        <= '0;
         y        <= '0;
         colour   <= COLOUR_W'(BLACK);
         startx_q <= '0;
         starty_q <= '0;
         erase_q  <= 1'b0;
         bg_q     <= '0;
         v_d      <= 1'b0;
         last_d   <= 1'b0;
         ax_d     <= '0;
         ay_d     <= '0;
      end else begin
         busy   <= (state_nx != IDLE);
         done   <= (state_nx == DONE);
         v_d    <= issue_valid;
         last_d <= issue_valid && last;
         ax_d   <= ax;
         ay_d   <= ay;
         plot   <= pix_show;
         if (load) begin
            startx_q <= startx;
            starty_q <= starty;
            erase_q  <= erase;
            bg_q     <= bg_colour;
         end
         if (pix_show) begin
            x      <= startx_q + X_W'(ax_d);
            y      <= starty_q + Y_W'(ay_d);
            colour <= erase_q ? bg_q : rom_q;
         end
      end
   end

endmodule

// File: tb/tb_draw_sprite_blit.sv
// tb/tb_draw_sprite_blit.sv - table-driven self-checking bench for draw_sprite_blit
module tb_draw_sprite_blit;
   import draw_sprite_pkg::*;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic [1:0] frame_sel = '0;
   logic [7:0] startx = '0;
   logic [6:0] starty = '0;
   logic       erase = 1'b0;
   logic [2:0] bg_colour = '0;
   logic [6:0] rom_addr;
   logic [2:0] rom_q = '0;
   logic [7:0] x;
   logic [6:0] y;
   logic [2:0] colour;
   logic       plot, busy, done;

   logic [2:0] rom_mem [128];

   draw_sprite_blit dut (
      .clock(clock), .reset(reset), .start(start), .frame_sel(frame_sel),
      .startx(startx), .starty(starty), .erase(erase), .bg_colour(bg_colour),
      .rom_addr(rom_addr), .rom_q(rom_q), .x(x), .y(y), .colour(colour),
      .plot(plot), .busy(busy), .done(done)
   );

   always #5 clock = ~clock;
   always @(posedge clock) rom_q <= rom_mem[rom_addr];

   typedef struct {
      logic [1:0] frame;
      logic [7:0] sx;
      logic [6:0] sy;
      logic       erase;
      logic [2:0] bg;
      logic       all7;
      int         addr0;
      int         x0, y0, xl, yl;
   } vec_t;

   vec_t vecs [6];

   logic       plot_log [64];
   logic       busy_log [64];
   logic       done_log [64];
   logic [7:0] x_log [64];
   logic [6:0] y_log [64];
   logic [2:0] col_log [64];
   logic [6:0] addr_log [64];

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic fill_rom(input logic all7);
      for (int a = 0; a < 128; a++) rom_mem[a] = all7 ? 3'd7 : 3'((a % 7) + 1);
   endtask

   task automatic begin_draw(input vec_t v);
      fill_rom(v.all7);
      @(negedge clock);
      frame_sel = v.frame;
      startx    = v.sx;
      starty    = v.sy;
      erase     = v.erase;
      bg_colour = v.bg;
      start     = 1'b1;
   endtask

   // Sample i is taken half a cycle after edge i; start was accepted at edge 0.
   task automatic capture(input int ncyc, input int s_on, input int s_off, input int r_on);
      for (int i = 0; i < ncyc; i++) begin
         @(negedge clock);
         plot_log[i] = plot;
         busy_log[i] = busy;
         done_log[i] = done;
         x_log[i]    = x;
         y_log[i]    = y;
         col_log[i]  = colour;
         addr_log[i] = rom_addr;
         if (i == 0) start = 1'b0;
         if (i == s_on) start = 1'b1;
         if (i == s_off) start = 1'b0;
         if (i == r_on) reset = 1'b1;
         if (r_on >= 0 && i == r_on + 1) reset = 1'b0;
      end
   endtask

   task automatic check_draw(input string tag, input int base, input vec_t v);
      int first = -1, lastc = -1, np = 0, nd = 0, dat = -1, nb = 0, perr = 0;
      int fx = -1, fy = -1, lx = -1, ly = -1, ex_x, ex_y, ex_c;
      for (int c = 0; c < 30; c++) begin
         if (plot_log[base + c]) begin
            if (first < 0) begin
               first = c;
               fx = x_log[base + c];
               fy = y_log[base + c];
            end
            lastc = c;
            lx = x_log[base + c];
            ly = y_log[base + c];
            ex_x = (v.sx + np % 5) % 256;
            ex_y = (v.sy + np / 5) % 128;
            ex_c = v.erase ? int'(v.bg) : int'(rom_mem[v.frame * 25 + np]);
            if (int'(x_log[base + c]) != ex_x || int'(y_log[base + c]) != ex_y ||
                int'(col_log[base + c]) != ex_c) perr++;
            np++;
         end
         if (done_log[base + c]) begin
            nd++;
            dat = c;
         end
         if (c >= 1 && c <= 27 && busy_log[base + c]) nb++;
      end
      chk({tag, " first_plot_cycle"}, first, 2);
      chk({tag, " last_plot_cycle"}, lastc, 26);
      chk({tag, " plot_count"}, np, 25);
      chk({tag, " done_count"}, nd, 1);
      chk({tag, " done_cycle"}, dat, 27);
      chk({tag, " busy_cycles"}, nb, 27);
      chk({tag, " busy_after"}, int'(busy_log[base + 28]), 0);
      chk({tag, " rom_addr_first"}, int'(addr_log[base]), v.addr0);
      chk({tag, " rom_addr_last"}, int'(addr_log[base + 24]), v.addr0 + 24);
      chk({tag, " x_first"}, fx, v.x0);
      chk({tag, " y_first"}, fy, v.y0);
      chk({tag, " x_last"}, lx, v.xl);
      chk({tag, " y_last"}, ly, v.yl);
      chk({tag, " pixel_errors"}, perr, 0);
   endtask

   initial begin
      int np, nb, nd;
      vecs[0] = '{2'(FRAME_DOWN),  8'd10,  7'd20,  1'b0, 3'd0, 1'b0, 25, 10, 20, 14, 24};
      vecs[1] = '{2'(FRAME_RIGHT), 8'd253, 7'd126, 1'b0, 3'd0, 1'b0, 75, 253, 126, 1, 2};
      vecs[2] = '{2'(FRAME_LEFT),  8'd100, 7'd50,  1'b1, 3'(BLACK), 1'b1, 50, 100, 50, 104, 54};
      vecs[3] = '{2'(FRAME_UP),    8'd0,   7'd0,   1'b0, 3'd0, 1'b0, 0, 0, 0, 4, 4};
      vecs[4] = '{2'(FRAME_DOWN),  8'd10,  7'd20,  1'b1, 3'(YELLOW), 1'b0, 25, 10, 20, 14, 24};
      vecs[5] = '{2'(FRAME_UP),    8'd255, 7'd127, 1'b0, 3'd0, 1'b0, 0, 255, 127, 3, 3};
      fill_rom(1'b0);

      // Reset dominates a pending start.
      start = 1'b1;
      frame_sel = 2'd2;
      startx = 8'd77;
      repeat (3) @(negedge clock);
      chk("reset plot", int'(plot), 0);
      chk("reset busy", int'(busy), 0);
      chk("reset done", int'(done), 0);
      chk("reset x", int'(x), 0);
      chk("reset y", int'(y), 0);
      chk("reset colour", int'(colour), 0);
      chk("reset rom_addr", int'(rom_addr), 0);
      reset = 1'b0;
      start = 1'b0;
      @(negedge clock);

      for (int k = 0; k < 6; k++) begin
         begin_draw(vecs[k]);
         capture(30, -1, -1, -1);
         check_draw($sformatf("vec%0d", k), 0, vecs[k]);
      end

      // Start re-raised mid-draw and held through DONE: one draw, then the next right after.
      begin_draw(vecs[0]);
      capture(60, 4, 29, -1);
      check_draw("repulse_first", 0, vecs[0]);
      check_draw("repulse_second", 29, vecs[0]);

      // Reset seen at edge 10 aborts the draw with no done pulse.
      begin_draw(vecs[1]);
      capture(30, -1, -1, 9);
      np = 0; nb = 0; nd = 0;
      for (int c = 10; c < 30; c++) begin
         np += int'(plot_log[c]);
         nb += int'(busy_log[c]);
         nd += int'(done_log[c]);
      end
      chk("abort plots_before", int'(plot_log[2]) + int'(plot_log[9]), 2);
      chk("abort plots_after", np, 0);
      chk("abort busy_after", nb, 0);
      chk("abort done_after", nd, 0);
      begin_draw(vecs[0]);
      capture(30, -1, -1, -1);
      check_draw("after_reset", 0, vecs[0]);

`ifdef DRAW_SPRITE_TRANSPARENT_EN
      begin
         int first = -1, lastc = -1, cnt = 0, dat = -1;
         begin_draw(vecs[3]);
         for (int a = 0; a < 25; a++) if (a % 3 == 0) rom_mem[a] = 3'd0;
         capture(30, -1, -1, -1);
         for (int c = 0; c < 30; c++) begin
            if (plot_log[c]) begin
               if (first < 0) first = c;
               lastc = c;
               cnt++;
            end
            if (done_log[c]) dat = c;
         end
         chk("transp plot_count", cnt, 16);
         chk("transp first_plot", first, 3);
         chk("transp last_plot", lastc, 25);
         chk("transp done_cycle", dat, 27);
      end
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
